// File: rtl/spectrum_acq_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_acq_scheduler
// Description : Sequences one spectrometer acquisition. Clears the bin
//               accumulator, aligns accumulation to FFT frame boundaries,
//               enables it for N frames, then drains the 16-bit bins as a
//               little-endian byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module spectrum_acq_scheduler #(
    parameter int FFT_SIZE = 512,
    parameter int AVG_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [AVG_W-1:0] cfg_num_avg,
    input  logic             mag_valid,
    input  logic             mag_ready,
    input  logic             mag_last,
    output logic             acc_clear,
    output logic             acc_en,
    input  logic             rd_valid,
    input  logic [15:0]      rd_data,
    output logic             rd_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [AVG_W-1:0] frames_done
);

    localparam int                  c_WCNT_W    = (FFT_SIZE > 2) ? $clog2(FFT_SIZE) : 1;
    localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(FFT_SIZE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SYNC  = 3'd2;
    localparam logic [2:0] S_ACCUM = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic                r_acc_en;
    logic [AVG_W-1:0]    r_num_avg;
    logic [AVG_W-1:0]    r_frames_done;
    logic [15:0]         r_hold;
    logic                r_full;
    logic                r_phase_hi;
    logic [c_WCNT_W-1:0] r_word_cnt;

    logic w_start_ok;
    logic w_mag_frame_end;
    logic w_last_frame;
    logic w_last_word;
    logic w_out_valid;
    logic w_rd_ready;
    logic w_out_fire;
    logic w_rd_fire;

    assign w_start_ok      = (r_state == S_IDLE) && cfg_start && !cfg_abort;
    assign w_mag_frame_end = mag_valid && mag_ready && mag_last;
    assign w_last_frame    = (r_frames_done == (r_num_avg - AVG_W'(1)));
    assign w_last_word     = (r_word_cnt == c_LAST_WORD);
    assign w_out_valid     = (r_state == S_READ) && r_full;
    // The final word never requests a successor, so the accumulator is not
    // asked for a word beyond the end of the frame.
    assign w_rd_ready      = (r_state == S_READ) &&
                             (!r_full || (r_phase_hi && out_ready && !w_last_word));
    assign w_out_fire      = w_out_valid && out_ready;
    assign w_rd_fire       = rd_valid && w_rd_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs; abort overrides every transition
    always_comb begin
        w_state_next = r_state;
        acc_clear    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start_ok) w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                acc_clear    = 1'b1;
                w_state_next = S_SYNC;
            end
            S_SYNC: begin
                if (w_mag_frame_end) w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_mag_frame_end && w_last_frame) w_state_next = S_READ;
            end
            S_READ: begin
                if (w_out_fire && r_phase_hi && w_last_word) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (cfg_abort && (r_state != S_IDLE)) w_state_next = S_IDLE;
    end

    // Accumulator enable is registered from the upcoming state so it is glitch-free
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc_en <= 1'b0;
        end else begin
            r_acc_en <= (w_state_next == S_ACCUM);
        end
    end

    // Frame target latch and saturating frame counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_num_avg     <= AVG_W'(1);
            r_frames_done <= '0;
        end else if (w_start_ok) begin
            r_num_avg     <= (cfg_num_avg == '0) ? AVG_W'(1) : cfg_num_avg;
            r_frames_done <= '0;
        end else if ((r_state == S_ACCUM) && w_mag_frame_end && !cfg_abort &&
                     (r_frames_done != {AVG_W{1'b1}})) begin
            r_frames_done <= r_frames_done + AVG_W'(1);
        end
    end

    // Readout holding register, LO/HI byte phase and word counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold     <= '0;
            r_full     <= 1'b0;
            r_phase_hi <= 1'b0;
            r_word_cnt <= '0;
        end else if ((r_state != S_READ) || cfg_abort) begin
            r_full     <= 1'b0;
            r_phase_hi <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            if (w_rd_fire) begin
                r_hold     <= rd_data;
                r_full     <= 1'b1;
                r_phase_hi <= 1'b0;
            end else if (w_out_fire) begin
                if (!r_phase_hi) begin
                    r_phase_hi <= 1'b1;
                end else begin
                    r_full     <= 1'b0;
                    r_phase_hi <= 1'b0;
                end
            end
            if (w_out_fire && r_phase_hi) r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
        end
    end

    assign acc_en      = r_acc_en;
    assign rd_ready    = w_rd_ready;
    assign out_valid   = w_out_valid;
    assign out_data    = w_out_valid ? (r_phase_hi ? r_hold[15:8] : r_hold[7:0]) : 8'h00;
    assign frames_done = r_frames_done;

endmodule
`default_nettype wire
